// File: rtl/main_decoder.sv
// Main control decoder for the single-cycle MIPS processor.
// Maps the instruction opcode to datapath control strobes and the ALU
// operation class. Unsupported opcodes decode to a side-effect-free no-op
// and set a sticky debug flag that only a reset clears.
module main_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       memWrite,
  output logic       regWrite,
  output logic       aluSrc,
  output logic       jump,
  output logic       memtoReg,
  output logic       branch,
  output logic       regdst,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic       illegal_seen
);

  // Supported opcodes (instruction bits [31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation classes. For the immediate class the ALU decoder picks
  // the operation from opcode[2:0] (100 AND, 101 OR, 010 SLT).
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_IMM = 2'b11;

  // Control word layout, MSB first:
  // memWrite, regWrite, aluSrc, jump, memtoReg, branch, regdst, aluop[1:0]
  localparam logic [8:0] CTRL_RTYPE = {7'b0100001, ALU_FN};
  localparam logic [8:0] CTRL_LW    = {7'b0110100, ALU_ADD};
  localparam logic [8:0] CTRL_SW    = {7'b1010000, ALU_ADD};
  localparam logic [8:0] CTRL_BEQ   = {7'b0000010, ALU_SUB};
  localparam logic [8:0] CTRL_ADDI  = {7'b0110000, ALU_ADD};
  localparam logic [8:0] CTRL_IMM   = {7'b0110000, ALU_IMM};
  localparam logic [8:0] CTRL_J     = {7'b0001000, ALU_ADD};
  // Safe no-op: no register, memory or PC side effects.
  localparam logic [8:0] CTRL_NOP   = {7'b0000000, ALU_ADD};

  logic [8:0] ctrl_word;
  logic       illegal_dec;
  logic       illegal_seen_reg;

  // Opcode decode; anything not listed (including X/Z) falls to the no-op.
  always_comb begin
    ctrl_word   = CTRL_NOP;
    illegal_dec = 1'b1;
    case (opcode)
      OP_RTYPE: begin ctrl_word = CTRL_RTYPE; illegal_dec = 1'b0; end
      OP_LW:    begin ctrl_word = CTRL_LW;    illegal_dec = 1'b0; end
      OP_SW:    begin ctrl_word = CTRL_SW;    illegal_dec = 1'b0; end
      OP_BEQ:   begin ctrl_word = CTRL_BEQ;   illegal_dec = 1'b0; end
      OP_ADDI:  begin ctrl_word = CTRL_ADDI;  illegal_dec = 1'b0; end
      OP_ANDI:  begin ctrl_word = CTRL_IMM;   illegal_dec = 1'b0; end
      OP_ORI:   begin ctrl_word = CTRL_IMM;   illegal_dec = 1'b0; end
      OP_SLTI:  begin ctrl_word = CTRL_IMM;   illegal_dec = 1'b0; end
      OP_J:     begin ctrl_word = CTRL_J;     illegal_dec = 1'b0; end
      default:  begin ctrl_word = CTRL_NOP;   illegal_dec = 1'b1; end
    endcase
  end

  assign {memWrite, regWrite, aluSrc, jump, memtoReg, branch, regdst, aluop} = ctrl_word;
  assign illegal = illegal_dec;

  // Sticky record of any unsupported opcode seen since the last reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_seen_reg <= 1'b0;
    end else if (illegal_dec) begin
      illegal_seen_reg <= 1'b1;
    end
  end

  assign illegal_seen = illegal_seen_reg;

endmodule

// File: tb/tb_main_decoder.sv
// Directed testbench for main_decoder: table sweep of supported opcodes,
// exhaustive opcode sweep, sticky flag behaviour and async reset.
module tb_main_decoder;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       memWrite;
  logic       regWrite;
  logic       aluSrc;
  logic       jump;
  logic       memtoReg;
  logic       branch;
  logic       regdst;
  logic [1:0] aluop;
  logic       illegal;
  logic       illegal_seen;

  int compared = 0;
  int mismatched = 0;

  main_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .memWrite     (memWrite),
    .regWrite     (regWrite),
    .aluSrc       (aluSrc),
    .jump         (jump),
    .memtoReg     (memtoReg),
    .branch       (branch),
    .regdst       (regdst),
    .aluop        (aluop),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control word: memWrite regWrite aluSrc jump memtoReg branch regdst aluop
  logic [8:0] word;
  assign word = {memWrite, regWrite, aluSrc, jump, memtoReg, branch, regdst, aluop};

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Hand-written decode table from the opcode list.
  logic [5:0] op_tab  [9];
  logic [8:0] exp_tab [9];
  string      name_tab[9];

  initial begin
    op_tab[0] = 6'b000000; exp_tab[0] = 9'b0_1_0_0_0_0_1_10; name_tab[0] = "rtype";
    op_tab[1] = 6'b100011; exp_tab[1] = 9'b0_1_1_0_1_0_0_00; name_tab[1] = "lw";
    op_tab[2] = 6'b101011; exp_tab[2] = 9'b1_0_1_0_0_0_0_00; name_tab[2] = "sw";
    op_tab[3] = 6'b000100; exp_tab[3] = 9'b0_0_0_0_0_1_0_01; name_tab[3] = "beq";
    op_tab[4] = 6'b001000; exp_tab[4] = 9'b0_1_1_0_0_0_0_00; name_tab[4] = "addi";
    op_tab[5] = 6'b001100; exp_tab[5] = 9'b0_1_1_0_0_0_0_11; name_tab[5] = "andi";
    op_tab[6] = 6'b001101; exp_tab[6] = 9'b0_1_1_0_0_0_0_11; name_tab[6] = "ori";
    op_tab[7] = 6'b001010; exp_tab[7] = 9'b0_1_1_0_0_0_0_11; name_tab[7] = "slti";
    op_tab[8] = 6'b000010; exp_tab[8] = 9'b0_0_0_1_0_0_0_00; name_tab[8] = "j";
  end

  function automatic bit in_table(input logic [5:0] op);
    for (int k = 0; k < 9; k++) if (op_tab[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int legal_count;
    reset  = 1'b1;
    opcode = 6'b000000;
    #2;
    // Reset state: sticky flag clear, decode still follows opcode.
    check("reset_illegal_seen", {8'd0, illegal_seen}, 9'd0);
    check("reset_rtype_decode", word, 9'b0_1_0_0_0_0_1_10);
    $display("txn reset: word=%b illegal_seen=%b", word, illegal_seen);
    @(negedge clk);
    reset = 1'b0;

    // Supported opcode sweep.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      opcode = op_tab[k];
      #2;
      check({name_tab[k], "_word"}, word, exp_tab[k]);
      check({name_tab[k], "_illegal"}, {8'd0, illegal}, 9'd0);
      $display("txn %s opcode=%b word=%b illegal=%b", name_tab[k], opcode, word, illegal);
    end
    @(posedge clk); #1;
    check("seen_after_legal", {8'd0, illegal_seen}, 9'd0);

    // Unsupported opcode 111111.
    @(negedge clk);
    opcode = 6'b111111;
    #1;
    check("op3f_word", word, 9'd0);
    check("op3f_illegal", {8'd0, illegal}, 9'd1);
    check("op3f_seen_before_edge", {8'd0, illegal_seen}, 9'd0);
    @(posedge clk); #1;
    check("op3f_seen_after_edge", {8'd0, illegal_seen}, 9'd1);
    $display("txn op3f: word=%b illegal=%b illegal_seen=%b", word, illegal, illegal_seen);
    opcode = 6'b000000;
    @(posedge clk); #1;
    check("seen_sticky", {8'd0, illegal_seen}, 9'd1);

    // Exhaustive sweep of all opcodes.
    legal_count = 0;
    for (int i = 0; i < 64; i++) begin
      opcode = 6'(i);
      #1;
      if (!illegal) legal_count++;
      check($sformatf("sweep_illegal_%0d", i), {8'd0, illegal}, {8'd0, !in_table(6'(i))});
      if (!in_table(6'(i)))
        check($sformatf("sweep_nop_%0d", i), word, 9'd0);
    end
    check("sweep_legal_count", 9'(legal_count), 9'd9);
    $display("txn sweep: legal_count=%0d", legal_count);

    // Asynchronous reset while the flag is set and opcode still illegal.
    @(negedge clk);
    opcode = 6'b111111;
    @(posedge clk); #1;
    check("pre_reset_seen", {8'd0, illegal_seen}, 9'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_clear", {8'd0, illegal_seen}, 9'd0);
    @(posedge clk); #1;
    check("held_in_reset", {8'd0, illegal_seen}, 9'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_release_no_edge", {8'd0, illegal_seen}, 9'd0);
    @(posedge clk); #1;
    check("reset_after_release_edge", {8'd0, illegal_seen}, 9'd1);
    $display("txn async_reset: illegal_seen=%b", illegal_seen);

    // beq held while reset and clk toggle: decode must not move.
    opcode = 6'b000100;
    for (int t = 0; t < 8; t++) begin
      #3 reset = ~reset;
      #1;
      check($sformatf("beq_hold_%0d", t), word, 9'b0_0_0_0_0_1_0_01);
    end
    reset = 1'b0;
    $display("txn beq_hold: word=%b", word);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
